grf_writeback: RTL and testbench
================================

# grf_writeback

Write-back stage of the five-stage MIPS pipeline; the producer side of the general register file's single write port. Captures the retiring MEM-stage instruction in the W pipeline register, selects and load-extends the result, and drives the GRF write enable, address, data and PC+4 trace value one cycle later. Also exports the same write as the W-stage forwarding source and keeps a retired-write counter. Exceptions and interrupts squash the MEM instruction here so it never commits.

## Interface
- RESET_PC, 32'h0000_3000, value loaded into the captured PC at reset; the reset value of grf_pc_plus_4 is RESET_PC+4.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low.
- m_valid  in  1  MEM slot holds a real instruction.
- m_regwrite  in  1  instruction writes the GRF.
- m_dst  in  5  destination register.
- m_wsel  in  2  result source: 0 = ALU, 1 = load, 2 = PC+8 (link), 3 = CP0 read.
- m_pc  in  32  instruction PC.
- m_alu  in  32  ALU result.
- m_mem_rdata  in  32  raw memory word.
- m_addr_lo  in  2  byte offset of the load address.
- m_ld_type  in  3  0 = lw, 1 = lb, 2 = lbu, 3 = lh, 4 = lhu; 5..7 are treated as lw.
- m_cp0_rdata  in  32  CP0 read value.
- stall  in  1  MEM is not advancing this cycle.
- flush  in  1  exception or interrupt commits this cycle.
- grf_we  out  1  GRF write enable.
- grf_a3  out  5  GRF write address.
- grf_wd  out  32  GRF write data.
- grf_pc_plus_4  out  32  captured PC+4, used for the trace print.
- fwd_valid / fwd_dst / fwd_data  out  1/5/32  W-stage forwarding source.
- retired_cnt  out  32  number of GRF writes committed.

## Operation
- W register fields: valid, regwrite, dst, wsel, pc, alu, rdata, addr_lo, ld_type, cp0.
- Update on every rising clk edge:
  - valid <= m_valid & ~stall & ~flush.
  - All other fields load unconditionally.
  - A stalled or flushed cycle therefore becomes a bubble. W never holds, so the same write is never issued twice.
- Result select (combinational from W):
  - ALU: alu.
  - Load: extended rdata.
  - Link: pc+8.
  - CP0: cp0.
- Load extension:
  - lb/lbu select byte rdata[8*addr_lo +: 8]; sign- or zero-extend.
  - lh/lhu select rdata[31:16] if addr_lo[1] else rdata[15:0]; addr_lo[0] is ignored, because misaligned accesses are trapped in MEM. Sign- or zero-extend.
- grf_we = valid & regwrite & (dst != 0). Writes to $0 are suppressed here, not only inside the GRF.
- grf_a3 = dst; grf_wd = selected result; grf_pc_plus_4 = pc + 4 (32-bit, wraps).
- fwd_valid = grf_we; fwd_dst and fwd_data equal grf_a3 and grf_wd.
- retired_cnt increments on each clock edge where grf_we = 1; 32-bit, wraps to 0.

## Timing
- Latency: MEM inputs sampled at edge N appear on the grf_* outputs after edge N; the GRF commits them at edge N+1.
- Outputs are combinational from W flops only. There is no combinational path from any m_* input, stall or flush to any output.
- stall and flush together: bubble (same as either alone).
- Reset assertion, including mid-operation, asynchronously clears:
  - valid, regwrite, dst, wsel, alu, rdata, addr_lo, ld_type and cp0 to 0;
  - pc to RESET_PC.
- Resulting output values during reset: grf_we = 0, grf_a3 = 0, grf_wd = 0 (wsel = ALU, alu = 0), grf_pc_plus_4 = RESET_PC+4, fwd_valid = 0, fwd_dst = 0, fwd_data = 0, retired_cnt = 0.
- After reset deasserts, the first capture occurs at the next rising edge.

## Structure
- Shared package mips_defs: WSEL_ALU/LOAD/LINK/CP0, LD_LW/LB/LBU/LH/LHU, RESET_PC default.
- Sub-module load_ext: purely combinational byte/halfword select and extension; ports rdata, addr_lo, ld_type -> ext.
- Top level holds the W register, result mux, write gating and retire counter.

## Test plan
- ALU write: m_valid=1, regwrite=1, dst=8, wsel=ALU, alu=32'h1234, pc=32'h3000 -> next cycle grf_we=1, a3=8, wd=32'h1234, pc_plus_4=32'h3004; retired_cnt=1 after the following edge.
- Loads: rdata=32'h80FF7F01.
  - lb addr_lo=3 -> wd=32'hFFFFFF80.
  - lbu addr_lo=2 -> 32'h000000FF.
  - lh addr_lo=2 -> 32'hFFFF80FF.
  - lhu addr_lo=0 -> 32'h00007F01.
- Link and $0: wsel=LINK, pc=32'h3010, dst=31 -> wd=32'h3018. The same instruction with dst=0 -> grf_we=0 and the counter is unchanged.
- Flush/stall: flush=1 alongside a valid write -> grf_we=0 next cycle. Three consecutive stalled cycles with a valid write held -> zero writes, then exactly one write once stall drops.
- Reset: assert reset low between edges while grf_we=1 -> grf_we=0 and retired_cnt=0 immediately, before the next edge. Then release reset and confirm normal capture resumes on the next edge.

Source files
------------

// File: rtl/grf_writeback_pkg.sv
// mips_defs: shared encodings for the write-back stage (result select, load type, reset PC, W register layout)
package mips_defs;

    localparam logic [1:0] WSEL_ALU  = 2'd0;
    localparam logic [1:0] WSEL_LOAD = 2'd1;
    localparam logic [1:0] WSEL_LINK = 2'd2;
    localparam logic [1:0] WSEL_CP0  = 2'd3;

    localparam logic [2:0] LD_LW  = 3'd0;
    localparam logic [2:0] LD_LB  = 3'd1;
    localparam logic [2:0] LD_LBU = 3'd2;
    localparam logic [2:0] LD_LH  = 3'd3;
    localparam logic [2:0] LD_LHU = 3'd4;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic [4:0]  dst;
        logic [1:0]  wsel;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [1:0]  addr_lo;
        logic [2:0]  ld_type;
        logic [31:0] cp0;
    } w_reg_t;

endpackage

// File: rtl/grf_writeback_load_ext.sv
// load_ext: byte/halfword select and sign/zero extension of a raw load word
//   rdata   in  32  raw memory word
//   addr_lo in  2   byte offset of the load address
//   ld_type in  3   lw/lb/lbu/lh/lhu (5..7 behave as lw)
//   ext     out 32  extended load result
module load_ext
    import mips_defs::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  ld_type,
    output logic [31:0] ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Halfword offset bit 0 is ignored: misaligned halfwords never reach W.
    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        ext = (ld_type == LD_LB)  ? {{24{byte_sel[7]}}, byte_sel} :
              (ld_type == LD_LBU) ? {24'd0, byte_sel} :
              (ld_type == LD_LH)  ? {{16{half_sel[15]}}, half_sel} :
              (ld_type == LD_LHU) ? {16'd0, half_sel} :
                                    rdata;
    end

endmodule

// File: rtl/grf_writeback.sv
// grf_writeback: W pipeline register, result select, GRF write port, W forwarding source, retire counter
//   clk, reset (async active-low)
//   m_valid/m_regwrite/m_dst/m_wsel/m_pc/m_alu/m_mem_rdata/m_addr_lo/m_ld_type/m_cp0_rdata  MEM-stage instruction
//   stall, flush        turn the captured slot into a bubble
//   grf_we/grf_a3/grf_wd/grf_pc_plus_4  GRF write port and trace PC
//   fwd_valid/fwd_dst/fwd_data          W-stage forwarding source
//   retired_cnt                          committed GRF writes (wraps)
module grf_writeback
    import mips_defs::*;
#(
    parameter logic [31:0] RESET_PC_P = RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_valid,
    input  logic        m_regwrite,
    input  logic [4:0]  m_dst,
    input  logic [1:0]  m_wsel,
    input  logic [31:0] m_pc,
    input  logic [31:0] m_alu,
    input  logic [31:0] m_mem_rdata,
    input  logic [1:0]  m_addr_lo,
    input  logic [2:0]  m_ld_type,
    input  logic [31:0] m_cp0_rdata,
    input  logic        stall,
    input  logic        flush,
    output logic        grf_we,
    output logic [4:0]  grf_a3,
    output logic [31:0] grf_wd,
    output logic [31:0] grf_pc_plus_4,
    output logic        fwd_valid,
    output logic [4:0]  fwd_dst,
    output logic [31:0] fwd_data,
    output logic [31:0] retired_cnt
);

    w_reg_t      w;
    logic [31:0] ld_ext;

    // W never holds: a stalled or flushed MEM slot is captured as a bubble,
    // so one instruction can never be written twice.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w    <= '0;
            w.pc <= RESET_PC_P;
        end else begin
            w.valid    <= m_valid & ~stall & ~flush;
            w.regwrite <= m_regwrite;
            w.dst      <= m_dst;
            w.wsel     <= m_wsel;
            w.pc       <= m_pc;
            w.alu      <= m_alu;
            w.rdata    <= m_mem_rdata;
            w.addr_lo  <= m_addr_lo;
            w.ld_type  <= m_ld_type;
            w.cp0      <= m_cp0_rdata;
        end
    end

    load_ext u_load_ext (
        .rdata   (w.rdata),
        .addr_lo (w.addr_lo),
        .ld_type (w.ld_type),
        .ext     (ld_ext)
    );

    // $0 writes are dropped here so forwarding never sees them either.
    always_comb begin
        grf_we        = w.valid & w.regwrite & (w.dst != 5'd0);
        grf_a3        = w.dst;
        grf_wd        = (w.wsel == WSEL_LOAD) ? ld_ext :
                        (w.wsel == WSEL_LINK) ? w.pc + 32'd8 :
                        (w.wsel == WSEL_CP0)  ? w.cp0 :
                                                w.alu;
        grf_pc_plus_4 = w.pc + 32'd4;
        fwd_valid     = grf_we;
        fwd_dst       = grf_a3;
        fwd_data      = grf_wd;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            retired_cnt <= 32'd0;
        else if (grf_we)
            retired_cnt <= retired_cnt + 32'd1;
    end

endmodule

// File: tb/tb_grf_writeback.sv
// tb_grf_writeback: scoreboard bench for grf_writeback against a behavioural write-back model
module tb_grf_writeback;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        m_valid = 0, m_regwrite = 0, stall = 0, flush = 0;
    logic [4:0]  m_dst = 0;
    logic [1:0]  m_wsel = 0, m_addr_lo = 0;
    logic [2:0]  m_ld_type = 0;
    logic [31:0] m_pc = 0, m_alu = 0, m_mem_rdata = 0, m_cp0_rdata = 0;
    logic        grf_we, fwd_valid;
    logic [4:0]  grf_a3, fwd_dst;
    logic [31:0] grf_wd, grf_pc_plus_4, fwd_data, retired_cnt;

    grf_writeback dut (
        .clk(clk), .reset(reset),
        .m_valid(m_valid), .m_regwrite(m_regwrite), .m_dst(m_dst), .m_wsel(m_wsel),
        .m_pc(m_pc), .m_alu(m_alu), .m_mem_rdata(m_mem_rdata), .m_addr_lo(m_addr_lo),
        .m_ld_type(m_ld_type), .m_cp0_rdata(m_cp0_rdata), .stall(stall), .flush(flush),
        .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc_plus_4(grf_pc_plus_4),
        .fwd_valid(fwd_valid), .fwd_dst(fwd_dst), .fwd_data(fwd_data), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        v, rw, st, fl;
        bit [4:0]  dst;
        bit [1:0]  wsel, lo;
        bit [2:0]  lt;
        bit [31:0] pc, alu, rdata, cp0;
    } stim_t;

    typedef struct {
        bit        we;
        bit [4:0]  a3;
        bit [31:0] wd, pc4, cnt;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    bit   prev_we = 0;
    bit [31:0] model_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit [31:0] load_model(bit [31:0] r, bit [1:0] lo, bit [2:0] t);
        bit [31:0] b = (r >> (8 * lo)) & 32'hFF;
        bit [31:0] h = (lo >= 2) ? (r >> 16) : (r & 32'hFFFF);
        case (t)
            3'd1:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            3'd2:    return b;
            3'd3:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            3'd4:    return h;
            default: return r;
        endcase
    endfunction

    function automatic exp_t model(stim_t s);
        exp_t e;
        e.we  = s.v && !s.st && !s.fl && s.rw && s.dst != 0;
        e.a3  = s.dst;
        e.pc4 = s.pc + 4;
        case (s.wsel)
            2'd0:    e.wd = s.alu;
            2'd1:    e.wd = load_model(s.rdata, s.lo, s.lt);
            2'd2:    e.wd = s.pc + 8;
            default: e.wd = s.cp0;
        endcase
        return e;
    endfunction

    // Drive one MEM slot, let the edge capture it, and record what W must show.
    task automatic issue(input stim_t s);
        exp_t e;
        m_valid = s.v; m_regwrite = s.rw; m_dst = s.dst; m_wsel = s.wsel;
        m_pc = s.pc; m_alu = s.alu; m_mem_rdata = s.rdata; m_addr_lo = s.lo;
        m_ld_type = s.lt; m_cp0_rdata = s.cp0; stall = s.st; flush = s.fl;
        @(posedge clk);
        if (prev_we) model_cnt = model_cnt + 1;
        e = model(s);
        e.cnt = model_cnt;
        prev_we = e.we;
        q.push_back(e);
        #1;
    endtask

    function automatic stim_t mk(bit v, bit rw, bit [4:0] dst, bit [1:0] wsel, bit [31:0] pc,
                                 bit [31:0] alu, bit [31:0] rdata, bit [1:0] lo, bit [2:0] lt,
                                 bit st, bit fl);
        stim_t s;
        s.v = v; s.rw = rw; s.dst = dst; s.wsel = wsel; s.pc = pc; s.alu = alu;
        s.rdata = rdata; s.lo = lo; s.lt = lt; s.cp0 = 32'hC0C0_0000 ^ pc; s.st = st; s.fl = fl;
        return s;
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        s.v = ($urandom_range(0, 9) < 8); s.rw = ($urandom_range(0, 9) < 8);
        s.dst = 5'($urandom); s.wsel = 2'($urandom); s.pc = {$urandom, 2'b00} ;
        s.alu = $urandom; s.rdata = $urandom; s.lo = 2'($urandom); s.lt = 3'($urandom);
        s.cp0 = $urandom; s.st = ($urandom_range(0, 99) < 15); s.fl = ($urandom_range(0, 99) < 10);
        return s;
    endfunction

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("grf_we", 32'(grf_we), 32'(e.we));
            chk("grf_a3", 32'(grf_a3), 32'(e.a3));
            chk("grf_wd", grf_wd, e.wd);
            chk("grf_pc_plus_4", grf_pc_plus_4, e.pc4);
            chk("fwd_valid", 32'(fwd_valid), 32'(e.we));
            chk("fwd_dst", 32'(fwd_dst), 32'(e.a3));
            chk("fwd_data", fwd_data, e.wd);
            chk("retired_cnt", retired_cnt, e.cnt);
        end
    end

    initial begin
        #12;
        chk("rst_we", 32'(grf_we), 32'd0);
        chk("rst_a3", 32'(grf_a3), 32'd0);
        chk("rst_wd", grf_wd, 32'd0);
        chk("rst_pc4", grf_pc_plus_4, 32'h0000_3004);
        chk("rst_fwd_valid", 32'(fwd_valid), 32'd0);
        chk("rst_cnt", retired_cnt, 32'd0);
        reset = 1'b1;

        issue(mk(1, 1, 8, 2'd0, 32'h3000, 32'h1234, 0, 0, 0, 0, 0));
        issue(mk(1, 1, 9, 2'd1, 32'h3004, 0, 32'h80FF7F01, 2'd3, 3'd1, 0, 0));
        issue(mk(1, 1, 10, 2'd1, 32'h3008, 0, 32'h80FF7F01, 2'd2, 3'd2, 0, 0));
        issue(mk(1, 1, 11, 2'd1, 32'h300C, 0, 32'h80FF7F01, 2'd2, 3'd3, 0, 0));
        issue(mk(1, 1, 12, 2'd1, 32'h3010, 0, 32'h80FF7F01, 2'd0, 3'd4, 0, 0));
        issue(mk(1, 1, 31, 2'd2, 32'h3010, 0, 0, 0, 0, 0, 0));
        issue(mk(1, 1, 0, 2'd2, 32'h3010, 0, 0, 0, 0, 0, 0));
        issue(mk(1, 1, 13, 2'd3, 32'h3014, 0, 0, 0, 0, 0, 0));
        issue(mk(1, 1, 14, 2'd0, 32'h3018, 32'hAAAA, 0, 0, 0, 0, 1));
        issue(mk(1, 1, 14, 2'd0, 32'h3018, 32'hAAAA, 0, 0, 0, 1, 1));
        for (int i = 0; i < 3; i++)
            issue(mk(1, 1, 15, 2'd0, 32'h301C, 32'h5555, 0, 0, 0, 1, 0));
        issue(mk(1, 1, 15, 2'd0, 32'h301C, 32'h5555, 0, 0, 0, 0, 0));
        issue(mk(1, 1, 16, 2'd0, 32'hFFFF_FFFC, 32'h77, 0, 0, 0, 0, 0));

        for (int i = 0; i < 300; i++) issue(rnd());

        issue(mk(1, 1, 20, 2'd0, 32'h4000, 32'hBEEF, 0, 0, 0, 0, 0));
        @(negedge clk);
        #1;
        chk("pre_reset_we", 32'(grf_we), 32'd1);
        reset = 1'b0;
        #1;
        chk("async_rst_we", 32'(grf_we), 32'd0);
        chk("async_rst_cnt", retired_cnt, 32'd0);
        chk("async_rst_wd", grf_wd, 32'd0);
        chk("async_rst_pc4", grf_pc_plus_4, 32'h0000_3004);
        prev_we = 0;
        model_cnt = 0;
        #1;
        reset = 1'b1;
        issue(mk(1, 1, 21, 2'd0, 32'h5000, 32'hCAFE, 0, 0, 0, 0, 0));
        issue(mk(1, 1, 22, 2'd1, 32'h5004, 0, 32'h1234_8765, 2'd1, 3'd1, 0, 0));
        for (int i = 0; i < 50; i++) issue(rnd());
        issue(mk(0, 0, 0, 2'd0, 32'h6000, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
